// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter: the processor gets the port by default, and host
// bursts use idle cycles or a forced slot after a run of denied cycles.
module mem_port_arbiter #(
    parameter int STARVE_LIM = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [47:0] cpu_wdata,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic [47:0] cpu_rdata,
    input  logic        host_start,
    input  logic        host_we,
    input  logic [15:0] host_base,
    input  logic [7:0]  host_len,
    input  logic [47:0] host_wdata,
    output logic        host_wready,
    output logic        host_rvalid,
    output logic [47:0] host_rdata,
    output logic        host_busy,
    output logic        host_done,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [47:0] mem_wdata,
    input  logic [47:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIM + 2);

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic          we_q;
    logic [15:0]   ptr;
    logic [7:0]    rem;
    logic [SW-1:0] starve;
    logic [47:0]   cpu_hold;
    logic [47:0]   host_hold;
    logic          forced;
    logic          host_grant;
    logic          cpu_grant;

    always_comb begin
        forced      = (state == BURST) && (starve == SW'(STARVE_LIM));
        host_grant  = rst && (state == BURST) && (!cpu_req || forced);
        cpu_grant   = rst && cpu_req && !host_grant;
        cpu_stall   = rst && cpu_req && !cpu_grant;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 16'h0;
        mem_wdata   = 48'h0;
        host_wready = 1'b0;
        if (cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_grant) begin
            mem_en   = 1'b1;
            mem_we   = we_q;
            mem_addr = ptr;
            if (we_q) begin
                mem_wdata   = host_wdata;
                host_wready = 1'b1;
            end
        end
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (host_start) begin
                    state_nx = (host_len == 8'd0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (host_grant && rem == 8'd1) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Load data is passed straight through on the return beat and held after.
    assign cpu_rdata  = cpu_rvalid  ? mem_rdata : cpu_hold;
    assign host_rdata = host_rvalid ? mem_rdata : host_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            we_q        <= 1'b0;
            ptr         <= 16'h0;
            rem         <= 8'h0;
            starve      <= '0;
            cpu_rvalid  <= 1'b0;
            host_rvalid <= 1'b0;
            cpu_hold    <= 48'h0;
            host_hold   <= 48'h0;
            host_busy   <= 1'b0;
            host_done   <= 1'b0;
        end else begin
            host_busy   <= (state_nx == BURST);
            host_done   <= (state_nx == DONE);
            cpu_rvalid  <= cpu_grant && !cpu_we;
            host_rvalid <= host_grant && !we_q;
            if (cpu_rvalid) begin
                cpu_hold <= mem_rdata;
            end
            if (host_rvalid) begin
                host_hold <= mem_rdata;
            end
            if (state == IDLE && host_start) begin
                we_q <= host_we;
                ptr  <= host_base;
                rem  <= host_len;
            end else if (host_grant) begin
                ptr <= ptr + 16'd1;
                rem <= rem - 8'd1;
            end
            if (state != BURST || host_grant) begin
                starve <= '0;
            end else if (cpu_req) begin
                starve <= starve + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-built corner
// sequences and random traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [47:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [47:0] cpu_rdata;
    logic        host_start;
    logic        host_we;
    logic [15:0] host_base;
    logic [7:0]  host_len;
    logic [47:0] host_wdata;
    logic        host_wready;
    logic        host_rvalid;
    logic [47:0] host_rdata;
    logic        host_busy;
    logic        host_done;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [47:0] mem_wdata;
    logic [47:0] mem_rdata = 48'h0;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.STARVE_LIM(STARVE)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_start(host_start), .host_we(host_we), .host_base(host_base),
        .host_len(host_len), .host_wdata(host_wdata),
        .host_wready(host_wready), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata), .host_busy(host_busy),
        .host_done(host_done), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] init_word(input logic [15:0] a);
        return {a, ~a, a ^ 16'h5A5A};
    endfunction

    // Synchronous RAM: read data appears in the cycle after the strobe
    logic [47:0] ram     [65536];
    bit          ram_wr  [65536];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : init_word(mem_addr);
            end
        end
    end

    // Reference model: pending burst addresses as a queue, a shadow memory
    logic [47:0] sh [logic [15:0]];
    logic [15:0] m_q[$];
    logic        m_busy = 0, m_done = 0, m_we = 0;
    int          m_denied = 0;
    logic        m_crv = 0, m_hrv = 0;
    logic [47:0] m_crd = 0, m_hrd = 0;

    logic        s_en, s_we, s_stall, s_wrdy, s_busy, s_done, s_crv, s_hrv;
    logic [15:0] s_addr;
    logic [47:0] s_crd;

    function automatic logic [47:0] shrd(input logic [15:0] a);
        return sh.exists(a) ? sh[a] : init_word(a);
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        logic        hg, cg, n_done, n_crv, n_hrv, idle;
        logic [15:0] ha;
        logic [47:0] e_wd;
        @(negedge clk);
        s_en = mem_en;      s_we = mem_we;       s_addr = mem_addr;
        s_stall = cpu_stall; s_wrdy = host_wready; s_busy = host_busy;
        s_done = host_done; s_crv = cpu_rvalid;  s_hrv = host_rvalid;
        s_crd = cpu_rdata;
        hg = rst && m_busy && (!cpu_req || m_denied == STARVE);
        cg = rst && cpu_req && !hg;
        ha = 16'h0;
        if (hg) ha = m_q[0];
        e_wd = hg ? host_wdata : (cg ? cpu_wdata : 48'h0);
        chk("mem_en", mem_en, hg || cg);
        chk("mem_we", mem_we, hg ? m_we : (cg & cpu_we));
        chk("mem_addr", mem_addr, hg ? ha : (cg ? cpu_addr : 16'h0));
        if (!(hg && !m_we)) chk("mem_wdata", mem_wdata, e_wd);
        chk("cpu_stall", cpu_stall, cpu_req && hg);
        chk("host_wready", host_wready, hg && m_we);
        chk("cpu_rvalid", cpu_rvalid, m_crv);
        chk("host_rvalid", host_rvalid, m_hrv);
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("host_rdata", host_rdata, m_hrd);
        chk("host_busy", host_busy, m_busy);
        chk("host_done", host_done, m_done);
        if (!rst) begin
            m_q.delete();
            m_busy = 0; m_done = 0; m_we = 0; m_denied = 0;
            m_crv = 0; m_hrv = 0; m_crd = 0; m_hrd = 0;
        end else begin
            idle  = !m_busy && !m_done;
            n_crv = cg && !cpu_we;
            n_hrv = hg && !m_we;
            if (n_crv) m_crd = shrd(cpu_addr);
            if (n_hrv) m_hrd = shrd(ha);
            if (cg && cpu_we) sh[cpu_addr] = cpu_wdata;
            if (hg && m_we) sh[ha] = host_wdata;
            n_done = 0;
            if (hg) begin
                void'(m_q.pop_front());
                m_denied = 0;
                if (m_q.size() == 0) begin
                    m_busy = 0;
                    n_done = 1;
                end
            end else if (m_busy) begin
                m_denied++;
            end
            if (idle && host_start) begin
                m_we = host_we;
                m_denied = 0;
                if (host_len == 0) n_done = 1;
                else begin
                    m_busy = 1;
                    for (int i = 0; i < host_len; i++) m_q.push_back(16'(host_base + i));
                end
            end
            m_done = n_done; m_crv = n_crv; m_hrv = n_hrv;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_start = 0; host_we = 0; host_base = 0; host_len = 0; host_wdata = 0;
    endtask

    typedef struct {
        logic rst, creq, cwe;
        logic [15:0] caddr;
        logic [47:0] cwd;
        logic hs, hwe;
        logic [15:0] hbase;
        logic [7:0]  hlen;
        logic en, we;
        logic [15:0] addr;
        logic stall, wrdy, busy, done, crv, hrv;
        logic [47:0] crd;
    } vec_t;

    function automatic vec_t mk(
        input logic r, cq, cw, input logic [15:0] ca, input logic [47:0] cd,
        input logic hs, hw, input logic [15:0] hb, input logic [7:0] hl,
        input logic en, we, input logic [15:0] ad,
        input logic st, wr, bs, dn, crv, hrv, input logic [47:0] crd);
        vec_t v;
        v.rst = r; v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.hs = hs; v.hwe = hw; v.hbase = hb; v.hlen = hl;
        v.en = en; v.we = we; v.addr = ad; v.stall = st; v.wrdy = wr;
        v.busy = bs; v.done = dn; v.crv = crv; v.hrv = hrv; v.crd = crd;
        return v;
    endfunction

    initial begin
        vec_t tv[$];
        quiet();
        rst = 0;
        @(posedge clk);
        #1;

        // rst creq cwe caddr cwdata  hs hwe base len | en we addr stall wrdy busy done crv hrv crd
        tv.push_back(mk(0,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,1,1,16'h0010,48'h123456789ABC, 0,0,16'h0,8'd0, 1,1,16'h0010,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,1,0,16'h0010,48'h0, 0,0,16'h0,8'd0, 1,0,16'h0010,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,0,1,0,48'h123456789ABC));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 1,1,16'h00FE,8'd4, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 1,1,16'h00FE,0,1,1,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 1,1,16'h00FF,0,1,1,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 1,1,16'h0100,0,1,1,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 1,1,16'h0101,0,1,1,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,1,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 1,0,16'h0050,8'd0, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,1,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 1,0,16'h0200,8'd8, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 1,0,16'h0200,0,0,1,0,0,0,48'h0));
        tv.push_back(mk(0,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,1,0,0,1,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 1,0,16'h0300,8'd2, 0,0,16'h0,0,0,0,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 1,0,16'h0300,0,0,1,0,0,0,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 1,0,16'h0301,0,0,1,0,0,1,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,1,0,1,48'h0));
        tv.push_back(mk(1,0,0,16'h0,48'h0, 0,0,16'h0,8'd0, 0,0,16'h0,0,0,0,0,0,0,48'h0));

        foreach (tv[i]) begin
            rst = tv[i].rst; cpu_req = tv[i].creq; cpu_we = tv[i].cwe;
            cpu_addr = tv[i].caddr; cpu_wdata = tv[i].cwd;
            host_start = tv[i].hs; host_we = tv[i].hwe;
            host_base = tv[i].hbase; host_len = tv[i].hlen;
            host_wdata = 48'hCAFE_0000_0000 + 48'(i);
            step();
            chk($sformatf("t%0d_en", i), s_en, tv[i].en);
            chk($sformatf("t%0d_we", i), s_we, tv[i].we);
            chk($sformatf("t%0d_addr", i), s_addr, tv[i].addr);
            chk($sformatf("t%0d_stall", i), s_stall, tv[i].stall);
            chk($sformatf("t%0d_wrdy", i), s_wrdy, tv[i].wrdy);
            chk($sformatf("t%0d_busy", i), s_busy, tv[i].busy);
            chk($sformatf("t%0d_done", i), s_done, tv[i].done);
            chk($sformatf("t%0d_crv", i), s_crv, tv[i].crv);
            chk($sformatf("t%0d_hrv", i), s_hrv, tv[i].hrv);
            if (tv[i].crv) chk($sformatf("t%0d_crd", i), s_crd, tv[i].crd);
        end

        // Read burst wrapping through 0xFFFF
        begin
            int na = 0, nrv = 0;
            logic [15:0] ad[3] = '{16'h0, 16'h0, 16'h0};
            logic last_done = 0;
            quiet();
            host_start = 1; host_we = 0; host_base = 16'hFFFE; host_len = 8'd3;
            step();
            quiet();
            for (int c = 0; c < 10; c++) begin
                step();
                if (s_en) begin
                    if (na < 3) ad[na] = s_addr;
                    na++;
                end
                if (s_hrv) begin
                    nrv++;
                    if (nrv == 3) last_done = s_done;
                end
            end
            chk("wrap_beats", 48'(na), 48'd3);
            chk("wrap_a0", ad[0], 16'hFFFE);
            chk("wrap_a1", ad[1], 16'hFFFF);
            chk("wrap_a2", ad[2], 16'h0000);
            chk("wrap_rvalids", 48'(nrv), 48'd3);
            chk("wrap_last_done", last_done, 1'b1);
        end

        // Starvation: CPU requests every cycle during a 2-beat host read
        begin
            int den = 0, nst = 0, gap[2] = '{0, 0};
            logic seen_done = 0;
            quiet();
            cpu_req = 1; cpu_addr = 16'h0777;
            host_start = 1; host_we = 0; host_base = 16'h0400; host_len = 8'd2;
            step();
            host_start = 0;
            for (int c = 0; c < 16 && !seen_done; c++) begin
                cpu_addr = 16'($urandom);
                step();
                if (s_stall) begin
                    if (nst < 2) gap[nst] = den;
                    nst++;
                    den = 0;
                end else if (s_busy) begin
                    den++;
                end
                if (s_done) seen_done = 1;
            end
            chk("starve_slots", 48'(nst), 48'd2);
            chk("starve_gap0", 48'(gap[0]), 48'(STARVE));
            chk("starve_gap1", 48'(gap[1]), 48'(STARVE));
            chk("starve_done", seen_done, 1'b1);
            quiet();
            step();
        end

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 149) != 0);
            cpu_req = $urandom_range(0, 1);
            cpu_we = $urandom_range(0, 1);
            cpu_addr = 16'($urandom_range(0, 31));
            cpu_wdata = {16'($urandom), 32'($urandom)};
            host_start = ($urandom_range(0, 5) == 0);
            host_we = $urandom_range(0, 1);
            host_base = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom_range(0, 31));
            host_len = 8'($urandom_range(0, 6));
            host_wdata = {16'($urandom), 32'($urandom)};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have one clock, clk; reset rst SHALL be synchronous and active-low.
REQ-002 Parameter: STARVE_LIM, default 4, maximum consecutive denied host cycles before a forced host slot.
REQ-003 Ports (name, direction, width, meaning):
- clk in 1: clock.
- rst in 1: synchronous active-low reset.
- cpu_req in 1: processor memory-stage access request.
- cpu_we in 1: processor write (1) or read (0).
- cpu_addr in 16: processor word address.
- cpu_wdata in 48: processor store data.
- cpu_stall out 1: processor request not granted this cycle.
- cpu_rvalid out 1: cpu_rdata valid.
- cpu_rdata out 48: processor load data.
- host_start in 1: start a host burst.
- host_we in 1: burst is a write (1) or read (0).
- host_base in 16: burst start address.
- host_len in 8: number of words in the burst.
- host_wdata in 48: host write data.
- host_wready out 1: host_wdata consumed this cycle.
- host_rvalid out 1: host_rdata valid.
- host_rdata out 48: host read data.
- host_busy out 1: burst in progress.
- host_done out 1: one-cycle burst-complete pulse.
- mem_en out 1: RAM access strobe.
- mem_we out 1: RAM write enable.
- mem_addr out 16: RAM word address.
- mem_wdata out 48: RAM write data.
- mem_rdata in 48: RAM read data, valid one cycle after the read strobe.

Function
REQ-004 The FSM SHALL have three states: IDLE, BURST, DONE.
REQ-005 IDLE: host_start=1 SHALL latch host_we, host_base and host_len.
- host_len>0: next state BURST.
- host_len=0: next state DONE with no RAM access.
REQ-006 host_start SHALL be ignored in BURST and DONE.
REQ-007 Each cycle at most one requester SHALL own the RAM port.
- Default: CPU wins whenever cpu_req=1.
- The host wins only in BURST when cpu_req=0 or the forced slot is due.
REQ-008 Starve counter:
- Increments each BURST cycle the host is denied.
- Clears on any host grant and in IDLE.
- When it equals STARVE_LIM, the host SHALL be granted that cycle, and cpu_stall=1 if cpu_req=1.
REQ-009 cpu_stall SHALL equal cpu_req AND NOT cpu_grant (combinational).
- Outside a forced slot, cpu_stall SHALL be 0.
REQ-010 CPU grant: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr and mem_wdata=cpu_wdata, combinationally in the same cycle.
REQ-011 Host grant: mem_en=1, mem_we=latched we, mem_addr=current burst pointer.
- On a write, also mem_wdata=host_wdata and host_wready=1.
- host_wready SHALL be 0 in every other cycle.
REQ-012 Burst pointer:
- Starts at host_base and increments by 1 per host grant.
- Wraps modulo 2^16 (0xFFFF to 0x0000).
- The remaining count decrements by 1 per host grant.
REQ-013 The grant that takes the remaining count to 0 SHALL move the FSM to DONE on the next cycle.
REQ-014 DONE SHALL last exactly one cycle with host_done=1, then return to IDLE.
REQ-015 host_busy SHALL be 1 exactly while in BURST (registered).
REQ-016 Read returns:
- A granted read SHALL produce rvalid=1 one cycle later on the owning port only (cpu_rvalid or host_rvalid).
- The rdata of that port SHALL equal mem_rdata in that cycle.
- The final host read beat's host_rvalid SHALL coincide with host_done.
REQ-017 cpu_rdata and host_rdata SHALL hold their last value when the corresponding rvalid=0.
REQ-018 When no requester is granted, mem_en and mem_we SHALL be 0.
- mem_addr and mem_wdata are then don't-care, but SHALL be driven to 0.

Reset
REQ-019 With rst=0 at a clock edge, the following SHALL be 0 on the next cycle: state (IDLE), starve counter, burst pointer, remaining count, all registered outputs (cpu_rvalid, cpu_rdata, host_rvalid, host_rdata, host_busy, host_done).
REQ-020 While rst=0, all combinational outputs (mem_en, mem_we, cpu_stall, host_wready) SHALL be 0.
REQ-021 Reset mid-burst SHALL abort the burst without a host_done pulse.
- A host_start in the first cycle after rst returns to 1 SHALL be accepted.

Verification
REQ-022 CPU write addr 0x0010 data 0x123456789ABC, then CPU read 0x0010 -> mem_we=1 in cycle t; cpu_rvalid=1 and cpu_rdata=0x123456789ABC in cycle t+2; cpu_stall=0 throughout.
REQ-023 Host write burst, base 0x00FE, len 4, cpu_req=0 -> mem_addr 0x00FE, 0x00FF, 0x0100, 0x0101 on consecutive cycles; host_wready=1 for those 4 cycles; host_done=1 in the following cycle; host_busy=0 after it.
REQ-024 Host read burst, base 0xFFFE, len 3 -> addresses 0xFFFE, 0xFFFF, 0x0000; three host_rvalid pulses, the third coinciding with host_done.
REQ-025 cpu_req held 1 during a host read burst of len 2, STARVE_LIM=4 -> host denied 4 cycles and granted on the 5th with cpu_stall=1; the pattern repeats for beat 2; host_done follows.
REQ-026 rst=0 in the second beat of a len-8 burst -> all outputs 0 next cycle; no host_done; a new host_start after release runs a normal burst.
REQ-027 host_start with host_len=0 -> no mem_en; host_done=1 exactly one cycle after start; FSM returns to IDLE.
